// File: rtl/memrow_param.sv
// memrow_param: one playfield row of WIDTH colour cells.
// The row stores per-cell colours and accepts single-cell writes and a
// whole-row load from the row above. It reports fullness, occupancy and
// four hitbox probes, and drives a registered pixel read port. A small
// sequencer flashes a full row, wipes it and pulses clear_done.
module memrow_param #(
  parameter int WIDTH     = 13,
  parameter int COLOR_W   = 3,
  parameter int IDX_W     = 6,
  parameter int FLASH_LEN = 8,
  parameter int BLINK_BIT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       advance,
  input  logic [WIDTH*COLOR_W-1:0]   shift_in,
  output logic [WIDTH*COLOR_W-1:0]   shift_out,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_col,
  input  logic [COLOR_W-1:0]         wr_color,
  input  logic                       clear_arm,
  output logic                       clear_busy,
  output logic                       clear_done,
  output logic                       row_full,
  output logic [$clog2(WIDTH+1)-1:0] occupancy,
  input  logic [4*IDX_W-1:0]         hit_cols,
  output logic [3:0]                 hit_status,
  input  logic [IDX_W-1:0]           rd_col,
  output logic [COLOR_W-1:0]         rd_color
);

  localparam int OCC_W    = $clog2(WIDTH + 1);
  // The counter must span FLASH_LEN-1 and also contain the blink bit.
  localparam int CNT_BASE = (FLASH_LEN > 1) ? $clog2(FLASH_LEN) : 1;
  localparam int CNT_W    = (CNT_BASE > BLINK_BIT) ? CNT_BASE : (BLINK_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Packed storage: cell i sits at [i*COLOR_W +: COLOR_W], matching shift_in.
  logic [WIDTH-1:0][COLOR_W-1:0] cells_r;
  logic [WIDTH-1:0][COLOR_W-1:0] cells_nxt_s;
  logic [WIDTH-1:0][COLOR_W-1:0] shift_in_s;
  state_t                        state_r;
  logic [CNT_W-1:0]              cnt_r;
  logic                          busy_r;
  logic                          done_r;
  logic [COLOR_W-1:0]            rd_color_r;
  logic [COLOR_W-1:0]            rd_nxt_s;
  logic                          rd_in_range_s;
  logic                          full_s;
  logic [OCC_W-1:0]              occ_s;
  logic [3:0]                    hit_s;
  logic                          flash_last_s;

  assign shift_in_s   = shift_in;
  assign shift_out    = cells_r;
  assign clear_busy   = busy_r;
  assign clear_done   = done_r;
  assign rd_color     = rd_color_r;
  assign row_full     = full_s;
  assign occupancy    = occ_s;
  assign hit_status   = hit_s;
  assign flash_last_s = (state_r == FLASH) && (cnt_r == CNT_LAST);

  // Next cell contents: wipe at the end of the flash, hold during it,
  // otherwise row load beats a single-cell write.
  always_comb begin
    cells_nxt_s = cells_r;
    if (state_r == FLASH) begin
      if (flash_last_s) begin
        cells_nxt_s = {WIDTH{{COLOR_W{1'b0}}}};
      end else begin
        cells_nxt_s = cells_r;
      end
    end else if (advance) begin
      cells_nxt_s = shift_in_s;
    end else if (wr_en) begin
      // Out-of-range columns match no cell, so the write falls away.
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_col == IDX_W'(i)) begin
          cells_nxt_s[i] = wr_color;
        end else begin
          cells_nxt_s[i] = cells_r[i];
        end
      end
    end else begin
      cells_nxt_s = cells_r;
    end
  end

  // Cell storage register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cells_r <= {WIDTH{{COLOR_W{1'b0}}}};
    end else begin
      cells_r <= cells_nxt_s;
    end
  end

  // Line-clear sequencer with registered busy/done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (clear_arm && full_s) begin
            state_r <= FLASH;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        FLASH: begin
          if (flash_last_s) begin
            state_r <= DONE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= FLASH;
            cnt_r   <= cnt_r + CNT_W'(1);
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          // clear_arm is ignored here; the row is empty anyway.
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read-port mux: out-of-range reads give 0, flash blink forces all-ones.
  always_comb begin
    rd_nxt_s      = {COLOR_W{1'b0}};
    rd_in_range_s = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (rd_col == IDX_W'(i)) begin
        rd_nxt_s      = cells_r[i];
        rd_in_range_s = 1'b1;
      end else begin
        rd_in_range_s = rd_in_range_s;
      end
    end
    if ((state_r == FLASH) && cnt_r[BLINK_BIT] && rd_in_range_s) begin
      rd_nxt_s = {COLOR_W{1'b1}};
    end else begin
      rd_nxt_s = rd_nxt_s;
    end
  end

  // Registered pixel colour towards the GPU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_color_r <= {COLOR_W{1'b0}};
    end else begin
      rd_color_r <= rd_nxt_s;
    end
  end

  // Fullness and occupancy straight from stored cells (never blinked).
  always_comb begin
    full_s = 1'b1;
    occ_s  = {OCC_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (cells_r[i] != {COLOR_W{1'b0}}) begin
        occ_s = occ_s + OCC_W'(1);
      end else begin
        full_s = 1'b0;
      end
    end
  end

  // Hitbox probes: out-of-range probe columns behave as walls.
  always_comb begin
    hit_s = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (hit_cols[j*IDX_W +: IDX_W] == IDX_W'(i)) begin
          hit_s[j] = (cells_r[i] != {COLOR_W{1'b0}});
        end else begin
          hit_s[j] = hit_s[j];
        end
      end
    end
  end

endmodule

// File: doc/memrow_param.md
Name: memrow_param

Overview:
- Parametrised successor of the fixed 13-cell playfield row: one row of WIDTH colour cells.
- Stores per-cell colours and supports single-cell writes and whole-row shift-down from the row above.
- Reports fullness, occupancy count and 4-point hitbox status, and serves a registered pixel-colour read port to the GPU.
- Adds an autonomous line-clear sequencer (flash, wipe, done pulse) so the game FSM only arms it and then waits for completion.

Parameters:
- WIDTH, 13: number of cells in the row.
- COLOR_W, 3: bits per cell colour; 0 means empty.
- IDX_W, 6: width of all column-index inputs.
- FLASH_LEN, 8: number of cycles the row flashes before it is wiped; must be ≥ 1.
- BLINK_BIT, 1: bit of the flash counter that selects the blink phase.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- advance  in  1  load every cell from shift_in (row collapse).
- shift_in  in  WIDTH*COLOR_W  packed colours of the row above; cell i at [i*COLOR_W +: COLOR_W].
- shift_out  out  WIDTH*COLOR_W  packed current colours, same packing as shift_in.
- wr_en  in  1  single-cell write strobe.
- wr_col  in  IDX_W  column to write.
- wr_color  in  COLOR_W  colour to write.
- clear_arm  in  1  game FSM permits a line clear.
- clear_busy  out  1  flash sequence in progress.
- clear_done  out  1  one-cycle pulse; row has been wiped.
- row_full  out  1  all cells non-zero (combinational from storage).
- occupancy  out  $clog2(WIDTH+1)  count of non-zero cells (combinational).
- hit_cols  in  4*IDX_W  four probe columns; probe j at [j*IDX_W +: IDX_W].
- hit_status  out  4  bit j = probe j is occupied.
- rd_col  in  IDX_W  GPU read column.
- rd_color  out  COLOR_W  registered colour of rd_col.

Behaviour:
- Reset (asynchronous) forces:
  - all cells, rd_color and the flash counter to 0;
  - FSM to IDLE;
  - clear_busy = 0 and clear_done = 0.
- Reset asserted mid-flash aborts the sequence with the same result.
- FSM states: IDLE, FLASH, DONE.
- IDLE:
  - advance = 1 → every cell loads from shift_in at the clock edge.
  - Otherwise wr_en = 1 with wr_col < WIDTH → cell[wr_col] ← wr_color.
  - advance and wr_en in the same cycle: advance wins and the write is dropped.
  - wr_col ≥ WIDTH: write ignored; no cell changes.
  - clear_arm = 1 and row_full = 1 at an edge → go to FLASH with counter = 0. An advance or write sampled at that same edge is still performed.
  - clear_arm with row_full = 0: no effect.
- FLASH:
  - clear_busy = 1.
  - Counter increments every cycle; wr_en, advance and clear_arm are ignored and cells hold.
  - When counter = FLASH_LEN-1: all cells ← 0 and state → DONE.
  - clear_busy is therefore high for exactly FLASH_LEN cycles.
- DONE:
  - clear_done = 1 for exactly one cycle, with cells already zero.
  - wr_en and advance are accepted as in IDLE, so the game FSM may start the collapse here.
  - clear_arm is ignored.
  - Next state is always IDLE.
- Read port (latency 1):
  - rd_color ← cell[rd_col] at each edge.
  - rd_col ≥ WIDTH → rd_color ← 0.
  - While in FLASH with counter[BLINK_BIT] = 1 → rd_color ← all-ones for in-range columns.
- hit_status (combinational):
  - bit j = (cell[probe j] ≠ 0).
  - A probe ≥ WIDTH reports 1, so out-of-range columns count as walls.
- row_full and occupancy reflect stored cells only; they are unaffected by blink or the read path.
- shift_out is always the raw stored cells, blink never applied, so a row below collapsing from this row receives true colours.
- No combinational path from wr_*/advance to row_full, occupancy or shift_out; those change only after the clock edge.

Test Plan:
All scenarios use WIDTH = 13, FLASH_LEN = 8, BLINK_BIT = 1.
- Reset/write/read: reset, then wr_en with col 4, colour 5 → next cycle rd_col = 4 gives rd_color = 5 one cycle later; occupancy = 1; row_full = 0. Writes with wr_col = 13 and wr_col = 63 leave occupancy = 1.
- Advance vs write: shift_in = all cells 3, with advance = 1 and wr_en (col 0, colour 6) in the same cycle → all cells 3, cell 0 = 3, occupancy = 13, row_full = 1.
- Clear sequence: full row, pulse clear_arm → clear_busy high for exactly 8 cycles. rd_color = 7 on flash counts 2, 3, 6, 7 and the stored colour on counts 0, 1, 4, 5. Next cycle clear_done = 1 for one cycle, occupancy = 0 and shift_out = 0.
- Busy lockout: during FLASH, drive wr_en (col 2, colour 1) and advance with shift_in = 0 → no cell changes, and the wipe still occurs at cycle 8. In DONE, a write to col 2 with colour 1 is accepted, giving occupancy = 1.
- Hitbox: cells 0 and 12 set, probes {0, 1, 12, 13} → hit_status = 4'b1101 (bit 0 = probe 0).
- Reset mid-flash: assert reset at flash count 3 → clear_busy = 0, clear_done never pulses, and all outputs are 0 asynchronously.
